// File: rtl/lc3b_memory.sv
// LC-3b main memory model: fixed-latency request/complete handshake over
// byte-laned word storage, with byte/word access and a sticky misalignment flag.
module lc3b_memory #(
  parameter int WAIT_STATES = 4,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        rw,
  input  logic        datasize,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mem_out,
  output logic        r,
  output logic        unaligned
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READY  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  capture;
  logic                  access_last;
  logic                  do_access;

  logic [DEPTH_LOG2:0]   addr_reg;
  logic [15:0]           wdata_reg;
  logic                  rw_reg;
  logic                  word_reg;
  logic [DEPTH_LOG2-1:0] idx;

  logic                  r_reg;
  logic                  unaligned_reg;
  logic                  out_word_reg;
  logic                  out_hi_reg;
  logic [15:0]           rd_word;

  // Address bits above the storage index are ignored, so addresses wrap.
  generate
    if (DEPTH_LOG2 < 15) begin : g_unused
      logic unused_mar_bits;
      assign unused_mar_bits = ^mar[15:DEPTH_LOG2+1];
    end
  endgenerate

  assign idx         = addr_reg[DEPTH_LOG2:1];
  assign access_last = (cnt_reg <= 4'd1);
  assign do_access   = (state_reg == ACCESS) && access_last && !reset;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mio_en) begin
          capture    = 1'b1;
          cnt_next   = WAIT_INIT;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // mio_en is deliberately not looked at here: an accepted request always completes.
        if (access_last) begin
          cnt_next   = 4'd0;
          state_next = READY;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      READY:   state_next = DONE;
      DONE:    if (!mio_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      r_reg         <= 1'b0;
      unaligned_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      r_reg         <= (state_next == READY);
      unaligned_reg <= unaligned_reg | (do_access & word_reg & addr_reg[0]);
    end
  end

  // Request fields are frozen at acceptance; bus changes mid-flight are ignored.
  always_ff @(posedge clk_50) begin
    if (capture && !reset) begin
      addr_reg  <= mar[DEPTH_LOG2:0];
      wdata_reg <= mdr_in;
      rw_reg    <= rw;
      word_reg  <= datasize;
    end
  end

  // Read formatting is latched with the read so later writes leave mem_out alone.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      out_word_reg <= 1'b0;
      out_hi_reg   <= 1'b0;
    end else if (do_access && !rw_reg) begin
      out_word_reg <= word_reg;
      out_hi_reg   <= addr_reg[0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;
      logic [7:0] lane_wdata;
      logic       lane_we;

      // Byte writes always take mdr_in[7:0], steered to the lane picked by mar[0].
      assign lane_we    = do_access && rw_reg && (word_reg || (addr_reg[0] == 1'(gi)));
      assign lane_wdata = word_reg ? wdata_reg[8*gi +: 8] : wdata_reg[7:0];

      always_ff @(posedge clk_50) begin
        if (lane_we) lane_mem[idx] <= lane_wdata;
      end

      always_ff @(posedge clk_50) begin
        if (reset)                      lane_rd_reg <= 8'h00;
        else if (do_access && !rw_reg)  lane_rd_reg <= lane_mem[idx];
      end

      assign rd_word[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

  assign mem_out   = out_word_reg ? rd_word
                                  : {8'h00, (out_hi_reg ? rd_word[15:8] : rd_word[7:0])};
  assign r         = r_reg;
  assign unaligned = unaligned_reg;

endmodule
